// File: rtl/interpolate4_pkg.sv
// -----------------------------------------------------------------------------
// interpolate4_pkg
// Shared types and defaults for the linear x4 interpolator.
//   state_e          : controller state (IDLE waits for a sample, EMIT ramps)
//   WIDTH_DEF        : default sample width in bits (unsigned samples)
//   FACTOR_LOG2_DEF  : default log2 of the interpolation factor
//   FACTOR           : number of output steps per input sample
// -----------------------------------------------------------------------------
package interpolate4_pkg;

    localparam int WIDTH_DEF       = 8;
    localparam int FACTOR_LOG2_DEF = 2;
    localparam int FACTOR          = 1 << FACTOR_LOG2_DEF;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_e;

endpackage : interpolate4_pkg

// File: rtl/interpolate4_if.sv
// -----------------------------------------------------------------------------
// interpolate4_if
// Sample-in / interpolated-out stream bundle of the x4 interpolator.
//   SampleIN    : new input sample (unsigned)
//   SampleValid : SampleIN is valid
//   SampleReady : interpolator accepts SampleIN this cycle
//   InterpOUT   : interpolated output sample
//   OutValid    : InterpOUT is valid
//   OutReady    : consumer accepts InterpOUT this cycle
// Modports: master = source/consumer side, slave = interpolator side.
// -----------------------------------------------------------------------------
interface interpolate4_if
    import interpolate4_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);

    logic [WIDTH-1:0] SampleIN;
    logic             SampleValid;
    logic             SampleReady;
    logic [WIDTH-1:0] InterpOUT;
    logic             OutValid;
    logic             OutReady;

    modport master (
        output SampleIN, SampleValid, OutReady,
        input  SampleReady, InterpOUT, OutValid
    );

    modport slave (
        input  SampleIN, SampleValid, OutReady,
        output SampleReady, InterpOUT, OutValid
    );

endinterface : interpolate4_if

// File: rtl/interpolate4_interp_step.sv
// -----------------------------------------------------------------------------
// interp_step
// Combinational ramp point: prev_i + ((k_i * (next_i - prev_i)) >>> FACTOR_LOG2).
//   prev_i   : ramp start (last emitted endpoint)
//   next_i   : ramp target
//   k_i      : step index 1..FACTOR
//   result_o : interpolated sample
// The arithmetic shift rounds toward minus infinity, so a falling ramp lands
// one LSB lower than truncation would; the result never leaves [prev, next].
// -----------------------------------------------------------------------------
module interp_step #(
    parameter int WIDTH       = 8,
    parameter int FACTOR_LOG2 = 2
) (
    input  logic [WIDTH-1:0]     prev_i,
    input  logic [WIDTH-1:0]     next_i,
    input  logic [FACTOR_LOG2:0] k_i,
    output logic [WIDTH-1:0]     result_o
);

    localparam int PW = WIDTH + FACTOR_LOG2 + 2;

    logic signed [WIDTH:0]  diff;
    logic signed [PW-1:0]   diff_ext;
    logic signed [PW-1:0]   k_ext;
    logic signed [PW-1:0]   product;
    logic signed [PW-1:0]   shifted;
    logic signed [PW-1:0]   prev_ext;

    assign diff     = $signed({1'b0, next_i}) - $signed({1'b0, prev_i});
    assign diff_ext = {{(PW - WIDTH - 1){diff[WIDTH]}}, diff};
    assign k_ext    = {{(PW - FACTOR_LOG2 - 1){1'b0}}, k_i};
    assign product  = diff_ext * k_ext;
    assign shifted  = product >>> FACTOR_LOG2;
    assign prev_ext = {{(PW - WIDTH){1'b0}}, prev_i};

    // The sum is provably within [0, 2^WIDTH-1]; the upper bits are discarded.
    assign result_o = WIDTH'(prev_ext + shifted);

endmodule : interp_step

// File: rtl/interpolate4.sv
// -----------------------------------------------------------------------------
// interpolate4
// Linear x4 interpolator: each accepted sample produces FACTOR evenly spaced
// outputs stepping from the previous endpoint to the new sample.
//   CLK  : clock, all logic on the rising edge
//   RSTn : synchronous active-low reset
//   bus  : interpolate4_if.slave stream bundle (sample in, ramp out)
// SampleReady depends combinationally on OutReady so that a new sample can be
// taken in the same cycle the last ramp step is consumed (zero-bubble stream).
// -----------------------------------------------------------------------------
module interpolate4
    import interpolate4_pkg::*;
#(
    parameter int WIDTH       = WIDTH_DEF,
    parameter int FACTOR_LOG2 = FACTOR_LOG2_DEF
) (
    input  logic           CLK,
    input  logic           RSTn,
    interpolate4_if.slave  bus
);

    localparam int              KW      = FACTOR_LOG2 + 1;
    localparam logic [KW-1:0]   K_FIRST = KW'(1);
    localparam logic [KW-1:0]   K_LAST  = KW'(1 << FACTOR_LOG2);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] prev_q,  prev_d;
    logic [WIDTH-1:0] next_q,  next_d;
    logic [KW-1:0]    k_q,     k_d;

    logic             last_step;

    assign last_step       = (k_q == K_LAST);
    assign bus.OutValid    = (state_q == EMIT);
    assign bus.SampleReady = (state_q == IDLE) || (last_step && bus.OutReady);

    interp_step #(
        .WIDTH       (WIDTH),
        .FACTOR_LOG2 (FACTOR_LOG2)
    ) u_step (
        .prev_i   (prev_q),
        .next_i   (next_q),
        .k_i      (k_q),
        .result_o (bus.InterpOUT)
    );

    always_comb begin
        // NOTE: every next-state signal gets its hold value first, so no path
        // through the case leaves a variable unassigned and no latch is inferred.
        state_d = state_q;
        prev_d  = prev_q;
        next_d  = next_q;
        k_d     = k_q;

        unique case (state_q)
            IDLE: begin
                if (bus.SampleValid) begin
                    next_d  = bus.SampleIN;
                    k_d     = K_FIRST;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                // Without OutReady everything holds, which keeps InterpOUT stable.
                if (bus.OutReady) begin
                    if (!last_step) begin
                        k_d = k_q + K_FIRST;
                    end else begin
                        prev_d = next_q;
                        if (bus.SampleValid) begin
                            next_d = bus.SampleIN;
                            k_d    = K_FIRST;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!RSTn) begin
            state_q <= IDLE;
            prev_q  <= '0;
            next_q  <= '0;
            k_q     <= K_FIRST;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            next_q  <= next_d;
            k_q     <= k_d;
        end
    end

endmodule : interpolate4

// File: tb/tb_interpolate4.sv
// -----------------------------------------------------------------------------
// tb_interpolate4
// Self-checking bench for interpolate4. Directed scenarios compare against
// hand-derived ramp values; the random scenario compares against a queue-based
// reference: every accepted sample appends its FACTOR ramp points to a queue
// of pending outputs, and each consumed output pops the head.
// -----------------------------------------------------------------------------
module tb_interpolate4;
    import interpolate4_pkg::*;

    localparam int W = 8;

    logic CLK;
    logic RSTn;

    interpolate4_if #(.WIDTH(W)) bus ();

    interpolate4 #(
        .WIDTH       (W),
        .FACTOR_LOG2 (FACTOR_LOG2_DEF)
    ) dut (
        .CLK  (CLK),
        .RSTn (RSTn),
        .bus  (bus.slave)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int checks = 0;
    int errors = 0;

    // Reference model: pending outputs and the last ramp endpoint.
    int m_queue[$];
    int m_prev = 0;

    // Values observed / predicted in the most recent tick (before its edge).
    logic       obs_valid, obs_ready;
    logic [W-1:0] obs_data;
    logic       exp_valid, exp_ready;
    int         exp_data;

    function automatic int floor_div(input int num, input int den);
        if (num >= 0) return num / den;
        return -((-num + den - 1) / den);
    endfunction

    // One clock cycle: drive inputs, observe outputs mid-cycle, advance the
    // reference model across the rising edge.
    task automatic tick(input logic sv, input logic [W-1:0] sin, input logic ordy);
        bus.SampleValid = sv;
        bus.SampleIN    = sin;
        bus.OutReady    = ordy;
        #1;
        obs_valid = bus.OutValid;
        obs_ready = bus.SampleReady;
        obs_data  = bus.InterpOUT;
        exp_valid = (m_queue.size() != 0);
        exp_data  = exp_valid ? m_queue[0] : 0;
        exp_ready = (m_queue.size() == 0) || (m_queue.size() == 1 && ordy);
        @(posedge CLK);
        if (!RSTn) begin
            m_queue.delete();
            m_prev = 0;
        end else begin
            if (exp_valid && ordy) void'(m_queue.pop_front());
            if (sv && exp_ready) begin
                for (int k = 1; k <= FACTOR; k++)
                    m_queue.push_back(m_prev + floor_div(k * (int'(sin) - m_prev), FACTOR));
                m_prev = int'(sin);
            end
        end
        #1;
    endtask

    task automatic do_reset();
        RSTn = 1'b0;
        tick(1'b0, '0, 1'b0);
        RSTn = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.OutValid !== 1'b0 || bus.SampleReady !== 1'b1 || bus.InterpOUT !== 8'd0) begin
            errors++;
            $display("FAIL reset: got valid=%b ready=%b data=%0d, expected valid=0 ready=1 data=0",
                     bus.OutValid, bus.SampleReady, bus.InterpOUT);
        end
    endtask

    // Isolated ramps: 0->100, 100->20, then from reset 0->3 and 3->0 (rounding).
    task automatic test_ramps();
        int samples[4] = '{100, 20, 3, 0};
        int expect_tab[4][4] = '{'{25, 50, 75, 100}, '{80, 60, 40, 20},
                                 '{0, 1, 2, 3},      '{2, 1, 0, 0}};
        do_reset();
        for (int s = 0; s < 4; s++) begin
            if (s == 2) do_reset();
            tick(1'b1, W'(samples[s]), 1'b1);
            checks++;
            if (obs_valid !== 1'b0 || obs_ready !== 1'b1) begin
                errors++;
                $display("FAIL ramp%0d_accept: got valid=%b ready=%b, expected valid=0 ready=1",
                         samples[s], obs_valid, obs_ready);
            end
            for (int k = 0; k < 4; k++) begin
                tick(1'b0, '0, 1'b1);
                checks++;
                if (obs_valid !== 1'b1 || obs_data !== W'(expect_tab[s][k])) begin
                    errors++;
                    $display("FAIL ramp%0d_step%0d: got valid=%b data=%0d, expected valid=1 data=%0d",
                             samples[s], k + 1, obs_valid, obs_data, expect_tab[s][k]);
                end
            end
            tick(1'b0, '0, 1'b1);
            checks++;
            if (obs_valid !== 1'b0 || obs_ready !== 1'b1) begin
                errors++;
                $display("FAIL ramp%0d_idle: got valid=%b ready=%b, expected valid=0 ready=1",
                         samples[s], obs_valid, obs_ready);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        tick(1'b1, 8'd100, 1'b1);
        tick(1'b0, '0, 1'b1);
        checks++;
        if (obs_data !== 8'd25) begin
            errors++;
            $display("FAIL bp_k1: got data=%0d, expected 25", obs_data);
        end
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 8'd77, 1'b0);
            checks++;
            if (obs_valid !== 1'b1 || obs_data !== 8'd50 || obs_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_stall%0d: got valid=%b data=%0d ready=%b, expected valid=1 data=50 ready=0",
                         i, obs_valid, obs_data, obs_ready);
            end
        end
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, '0, 1'b1);
            checks++;
            if (obs_valid !== 1'b1 || obs_data !== W'(50 + 25 * i)) begin
                errors++;
                $display("FAIL bp_resume%0d: got valid=%b data=%0d, expected valid=1 data=%0d",
                         i, obs_valid, obs_data, 50 + 25 * i);
            end
        end
        tick(1'b0, '0, 1'b1);
        checks++;
        if (obs_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_idle: got valid=%b, expected 0", obs_valid);
        end
    endtask

    // Stream 40, 80, 0 with SampleValid held; junk on SampleIN when not ready.
    task automatic test_back_to_back();
        int expect_seq[12] = '{10, 20, 30, 40, 50, 60, 70, 80, 60, 40, 20, 0};
        logic [W-1:0] sin;
        do_reset();
        tick(1'b1, 8'd40, 1'b1);
        for (int i = 1; i <= 12; i++) begin
            sin = (i == 4) ? 8'd80 : (i == 8) ? 8'd0 : W'($urandom_range(0, 255));
            tick(i < 12, sin, 1'b1);
            checks++;
            if (obs_valid !== 1'b1 || obs_data !== W'(expect_seq[i-1]) || obs_ready !== (i % 4 == 0)) begin
                errors++;
                $display("FAIL b2b_cycle%0d: got valid=%b data=%0d ready=%b, expected valid=1 data=%0d ready=%b",
                         i, obs_valid, obs_data, obs_ready, expect_seq[i-1], (i % 4 == 0));
            end
        end
        tick(1'b0, '0, 1'b1);
        checks++;
        if (obs_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: got valid=%b, expected 0", obs_valid);
        end
    endtask

    task automatic test_reset_mid_ramp();
        do_reset();
        tick(1'b1, 8'd200, 1'b1);
        tick(1'b0, '0, 1'b1);
        RSTn = 1'b0;
        tick(1'b0, '0, 1'b1);
        RSTn = 1'b1;
        checks++;
        if (obs_valid !== 1'b1 || obs_data !== 8'd100) begin
            errors++;
            $display("FAIL midrst_k2: got valid=%b data=%0d, expected valid=1 data=100", obs_valid, obs_data);
        end
        tick(1'b1, 8'd8, 1'b1);
        checks++;
        if (obs_valid !== 1'b0 || obs_ready !== 1'b1 || obs_data !== 8'd0) begin
            errors++;
            $display("FAIL midrst_after: got valid=%b ready=%b data=%0d, expected valid=0 ready=1 data=0",
                     obs_valid, obs_ready, obs_data);
        end
        for (int k = 1; k <= 4; k++) begin
            tick(1'b0, '0, 1'b1);
            checks++;
            if (obs_valid !== 1'b1 || obs_data !== W'(2 * k)) begin
                errors++;
                $display("FAIL midrst_ramp%0d: got valid=%b data=%0d, expected valid=1 data=%0d",
                         k, obs_valid, obs_data, 2 * k);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            RSTn = ($urandom_range(0, 99) != 0);
            tick($urandom_range(0, 1) == 1, W'($urandom_range(0, 255)), $urandom_range(0, 3) != 0);
            checks++;
            if (obs_valid !== exp_valid || obs_ready !== exp_ready ||
                (exp_valid && obs_data !== W'(exp_data))) begin
                errors++;
                $display("FAIL random%0d: got valid=%b ready=%b data=%0d, expected valid=%b ready=%b data=%0d",
                         i, obs_valid, obs_ready, obs_data, exp_valid, exp_ready, exp_data);
            end
        end
        RSTn = 1'b1;
    endtask

    initial begin
        RSTn            = 1'b0;
        bus.SampleValid = 1'b0;
        bus.SampleIN    = '0;
        bus.OutReady    = 1'b0;
        @(posedge CLK);
        #1;
        test_reset();
        test_ramps();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_ramp();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_interpolate4
